// File: rtl/pool2x2_stream_bank_if.sv
// Stream bundle for pool2x2_stream_bank.
// The input side carries channel-parallel pixels in raster order.
// The output side carries pooled pixels and an end-of-frame marker.
// Both sides use a valid/ready handshake, with channel c at bits [c*DW +: DW].
//   master : drives in_valid/in_data/out_ready, observes in_ready/out_*
//   slave  : the pooling bank itself
interface pool2x2_stream_bank_if #(
  parameter int CH = 6,
  parameter int DW = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CH*DW-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CH*DW-1:0]  out_data;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool2x2_stream_bank.sv
// 2x2 / stride-2 pooling bank for a channel-parallel pixel stream.
// Each input beat carries CH signed samples of DW bits.
// An optional ReLU is applied first. Pooling is either max or average.
// Horizontal pairs are formed with a hold register.
// Vertical pairs are formed through a half-width line buffer.
// A trailing odd column or row is consumed but never pooled.
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   frm_clr  synchronous frame restart; drops any pending output
//   bus      pool2x2_stream_bank_if.slave (in_* / out_* handshake)
module pool2x2_stream_bank #(
  parameter int FM_W      = 28,
  parameter int FM_H      = 28,
  parameter int CH        = 6,
  parameter int DW        = 16,
  parameter int RELU_EN   = 1,
  parameter int POOL_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frm_clr,
  pool2x2_stream_bank_if.slave   bus
);

  localparam int HW = FM_W / 2;
  localparam int HH = FM_H / 2;
  // Counters are sized so that 2*HW and 2*HH are representable for the compares.
  localparam int CW = $clog2(FM_W + 1);
  localparam int RW = $clog2(FM_H + 1);
  localparam int IW = (HW > 1) ? $clog2(HW) : 1;

  typedef logic        [CW-1:0] col_t;
  typedef logic        [RW-1:0] row_t;
  typedef logic        [CW-2:0] half_t;
  typedef logic        [IW-1:0] idx_t;
  typedef logic signed [DW-1:0] data_t;
  typedef logic signed [DW:0]   pair_t;   // horizontal result, one guard bit
  typedef logic signed [DW+1:0] quad_t;   // vertical sum, two guard bits

  localparam col_t  COL_MAX  = col_t'(FM_W - 1);
  localparam col_t  COL_LAST = col_t'(2 * HW - 1);
  localparam row_t  ROW_MAX  = row_t'(FM_H - 1);
  localparam row_t  ROW_LAST = row_t'(2 * HH - 1);
  localparam row_t  ROW_LIM  = row_t'(2 * HH);
  localparam half_t HW_L     = half_t'(HW);

  col_t               col;
  row_t               row;
  data_t              hold [CH];
  pair_t              lb   [CH][HW];
  logic               out_valid_q;
  logic               out_last_q;
  logic [CH*DW-1:0]   out_data_q;

  logic               fire;
  logic               pool_fire;
  half_t              col_half;
  idx_t               idx;
  data_t              s [CH];
  pair_t              h [CH];
  data_t              x;
  pair_t              lb_rd;
  quad_t              quad;
  logic [CH*DW-1:0]   v_flat;

  // Ready is purely a function of the output stage: no skid buffer, so a
  // stalled result blocks the input, and a frame restart refuses the beat.
  assign bus.in_ready  = !frm_clr && !(out_valid_q && !bus.out_ready);
  assign fire          = bus.in_valid && bus.in_ready;

  // An odd column is always below 2*HW and an odd row always below 2*HH, so
  // the odd/odd test alone selects the pooled beats and skips trailing lines.
  assign pool_fire     = fire && col[0] && row[0];

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_data  = out_data_q;

  // A trailing even column (odd FM_W) would index one past the buffer; its
  // read is never used, so it is steered to entry 0.
  assign col_half = col[CW-1:1];
  assign idx      = (col_half < HW_L) ? idx_t'(col_half) : '0;

  always_comb begin
    // NOTE: every variable written here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    v_flat = '0;
    x      = '0;
    lb_rd  = '0;
    quad   = '0;
    for (int c = 0; c < CH; c++) begin
      x    = data_t'(bus.in_data[c*DW +: DW]);
      s[c] = (RELU_EN != 0 && x < 0) ? data_t'(0) : x;

      if (POOL_MODE == 0) begin
        h[c] = (hold[c] > s[c]) ? pair_t'(hold[c]) : pair_t'(s[c]);
      end else begin
        h[c] = pair_t'(hold[c]) + pair_t'(s[c]);
      end

      lb_rd = lb[c][idx];
      if (POOL_MODE == 0) begin
        v_flat[c*DW +: DW] = (lb_rd > h[c]) ? data_t'(lb_rd) : data_t'(h[c]);
      end else begin
        // Arithmetic shift floors toward -inf, e.g. -7/4 gives -2.
        quad               = quad_t'(lb_rd) + quad_t'(h[c]);
        v_flat[c*DW +: DW] = data_t'(quad >>> 2);
      end
    end
  end

  // Raster position of the next beat to be accepted.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (frm_clr) begin
      col <= '0;
      row <= '0;
    end else if (fire) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + row_t'(1);
      end else begin
        col <= col + col_t'(1);
      end
    end
  end

  // Hold register (even column) and line buffer (odd column, even row).
  // NOTE: the line buffer is a register array with async reset, so it
  // powers up to zero; it cannot map onto a RAM macro in this form.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        hold[c] <= '0;
        for (int i = 0; i < HW; i++) begin
          lb[c][i] <= '0;
        end
      end
    end else if (fire) begin
      for (int c = 0; c < CH; c++) begin
        if (!col[0]) begin
          hold[c] <= s[c];
        end else if (!row[0] && row < ROW_LIM) begin
          lb[c][idx] <= h[c];
        end
      end
    end
  end

  // Output register. A new result may load in the same cycle the previous
  // one is taken, because in_ready is high whenever out_ready is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (frm_clr) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (pool_fire) begin
      out_valid_q <= 1'b1;
      out_last_q  <= (col == COL_LAST) && (row == ROW_LAST);
      out_data_q  <= v_flat;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool2x2_stream_bank.sv
// Directed bench for pool2x2_stream_bank.
// Four instances, selected one at a time through sel, each cover a mode:
//   0: 4x4, CH=1, ReLU on,  max
//   1: 4x4, CH=2, ReLU off, average
//   2: 2x2, CH=1, ReLU off, max
//   3: 5x5, CH=1, ReLU on,  max
module tb_pool2x2_stream_bank;

  logic        clk;
  logic        rst_n;
  int          sel;
  logic        tv;
  logic [31:0] td;
  logic        tr;
  logic        tclr;

  logic        obs_v;
  logic        obs_l;
  logic        obs_rdy;
  logic [31:0] obs_d;

  int total = 0;
  int bad   = 0;

  logic        mon_en;
  logic [31:0] q_d[$];
  logic        q_l[$];
  logic [31:0] stim[$];

  pool2x2_stream_bank_if #(.CH(1), .DW(16)) if_m ();
  pool2x2_stream_bank_if #(.CH(2), .DW(16)) if_a ();
  pool2x2_stream_bank_if #(.CH(1), .DW(16)) if_n ();
  pool2x2_stream_bank_if #(.CH(1), .DW(16)) if_o ();

  logic clr_m, clr_a, clr_n, clr_o;
  assign clr_m = tclr && (sel == 0);
  assign clr_a = tclr && (sel == 1);
  assign clr_n = tclr && (sel == 2);
  assign clr_o = tclr && (sel == 3);

  assign if_m.in_valid = tv && (sel == 0);
  assign if_a.in_valid = tv && (sel == 1);
  assign if_n.in_valid = tv && (sel == 2);
  assign if_o.in_valid = tv && (sel == 3);
  assign if_m.in_data  = td[15:0];
  assign if_a.in_data  = td;
  assign if_n.in_data  = td[15:0];
  assign if_o.in_data  = td[15:0];
  assign if_m.out_ready = tr;
  assign if_a.out_ready = tr;
  assign if_n.out_ready = tr;
  assign if_o.out_ready = tr;

  pool2x2_stream_bank #(.FM_W(4), .FM_H(4), .CH(1), .DW(16), .RELU_EN(1), .POOL_MODE(0))
    u_m (.clk(clk), .rst_n(rst_n), .frm_clr(clr_m), .bus(if_m));
  pool2x2_stream_bank #(.FM_W(4), .FM_H(4), .CH(2), .DW(16), .RELU_EN(0), .POOL_MODE(1))
    u_a (.clk(clk), .rst_n(rst_n), .frm_clr(clr_a), .bus(if_a));
  pool2x2_stream_bank #(.FM_W(2), .FM_H(2), .CH(1), .DW(16), .RELU_EN(0), .POOL_MODE(0))
    u_n (.clk(clk), .rst_n(rst_n), .frm_clr(clr_n), .bus(if_n));
  pool2x2_stream_bank #(.FM_W(5), .FM_H(5), .CH(1), .DW(16), .RELU_EN(1), .POOL_MODE(0))
    u_o (.clk(clk), .rst_n(rst_n), .frm_clr(clr_o), .bus(if_o));

  always_comb begin
    obs_v = 1'b0; obs_l = 1'b0; obs_rdy = 1'b0; obs_d = '0;
    case (sel)
      0: begin obs_v = if_m.out_valid; obs_l = if_m.out_last; obs_rdy = if_m.in_ready; obs_d = {16'h0, if_m.out_data}; end
      1: begin obs_v = if_a.out_valid; obs_l = if_a.out_last; obs_rdy = if_a.in_ready; obs_d = if_a.out_data; end
      2: begin obs_v = if_n.out_valid; obs_l = if_n.out_last; obs_rdy = if_n.in_ready; obs_d = {16'h0, if_n.out_data}; end
      default: begin obs_v = if_o.out_valid; obs_l = if_o.out_last; obs_rdy = if_o.in_ready; obs_d = {16'h0, if_o.out_data}; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records each output beat that is taken at the next rising edge.
  always @(negedge clk) begin
    if (mon_en && obs_v && tr) begin
      q_d.push_back(obs_d);
      q_l.push_back(obs_l);
    end
  end

  // Offers one beat and returns just after the edge that accepts it.
  task automatic push(input logic [31:0] d);
    bit done;
    done = 1'b0;
    tv = 1'b1;
    td = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (obs_rdy) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    tv = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL push_timeout sel=%0d got in_ready=0 want 1 within 50 cycles", sel);
    end
  endtask

  task automatic send_stim();
    for (int i = 0; i < stim.size(); i++) push(stim[i]);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic start_capture();
    q_d.delete();
    q_l.delete();
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      total++;
      if (obs_v !== 1'b0 || obs_l !== 1'b0) begin
        bad++; $display("FAIL reset_flags sel=%0d got v=%b l=%b want 0 0", k, obs_v, obs_l);
      end
      total++;
      if (obs_d !== 32'h0) begin
        bad++; $display("FAIL reset_data sel=%0d got %h want 0", k, obs_d);
      end
    end
    sel = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_max();
    logic exp_v;
    sel = 0;
    for (int i = 0; i < 16; i++) begin
      push(32'(i));
      @(negedge clk);
      exp_v = (i == 5 || i == 7 || i == 13 || i == 15);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL max_valid beat=%0d got %b want %b", i, obs_v, exp_v);
      end
      if (exp_v) begin
        total++;
        if (obs_d !== 32'(i)) begin
          bad++; $display("FAIL max_data beat=%0d got %0d want %0d", i, obs_d, i);
        end
        total++;
        if (obs_l !== (i == 15)) begin
          bad++; $display("FAIL max_last beat=%0d got %b want %b", i, obs_l, (i == 15));
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_avg();
    logic [31:0] exp_d [4];
    exp_d[0] = {16'hFFFD, 16'd2};
    exp_d[1] = {16'hFFFD, 16'd4};
    exp_d[2] = {16'hFFFD, 16'd10};
    exp_d[3] = {16'hFFFD, 16'd12};
    sel = 1;
    start_capture();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back({16'hFFFD, 16'(i)});
    send_stim();
    total++;
    if (q_d.size() != 4) begin
      bad++; $display("FAIL avg_count got %0d want 4", q_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q_d[k] !== exp_d[k]) begin
          bad++; $display("FAIL avg_data idx=%0d got %h want %h", k, q_d[k], exp_d[k]);
        end
        total++;
        if (q_l[k] !== (k == 3)) begin
          bad++; $display("FAIL avg_last idx=%0d got %b want %b", k, q_l[k], (k == 3));
        end
      end
    end
    // Block {-1,-2,-2,-2} averages to -1.75 and must floor to -2.
    start_capture();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(32'h0);
    stim[0] = 32'h0000_FFFF;
    stim[1] = 32'h0000_FFFE;
    stim[4] = 32'h0000_FFFE;
    stim[5] = 32'h0000_FFFE;
    send_stim();
    total++;
    if (q_d.size() != 4) begin
      bad++; $display("FAIL avg_floor_count got %0d want 4", q_d.size());
    end else begin
      total++;
      if (q_d[0] !== 32'h0000_FFFE) begin
        bad++; $display("FAIL avg_floor got %h want 0000fffe", q_d[0]);
      end
    end
  endtask

  task automatic test_relu();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd0; exp_d[1] = 32'd7; exp_d[2] = 32'd13; exp_d[3] = 32'd15;
    sel = 0;
    start_capture();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(32'(i));
    stim[0] = 32'h0000_FFFB;
    stim[1] = 32'h0000_FFF9;
    stim[4] = 32'h0000_FFFF;
    stim[5] = 32'h0000_FFF7;
    send_stim();
    total++;
    if (q_d.size() != 4) begin
      bad++; $display("FAIL relu_count got %0d want 4", q_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q_d[k] !== exp_d[k]) begin
          bad++; $display("FAIL relu_data idx=%0d got %h want %h", k, q_d[k], exp_d[k]);
        end
      end
    end
    // Same block with ReLU disabled keeps the sign: max is -1.
    sel = 2;
    start_capture();
    stim.delete();
    stim.push_back(32'h0000_FFFB);
    stim.push_back(32'h0000_FFF9);
    stim.push_back(32'h0000_FFFF);
    stim.push_back(32'h0000_FFF7);
    send_stim();
    total++;
    if (q_d.size() != 1) begin
      bad++; $display("FAIL norelu_count got %0d want 1", q_d.size());
    end else begin
      total++;
      if (q_d[0] !== 32'h0000_FFFF || q_l[0] !== 1'b1) begin
        bad++; $display("FAIL norelu_data got %h last=%b want 0000ffff last=1", q_d[0], q_l[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd5; exp_d[1] = 32'd7; exp_d[2] = 32'd13; exp_d[3] = 32'd15;
    sel = 0;
    start_capture();
    for (int i = 0; i < 6; i++) push(32'(i));
    tr = 1'b0;
    tv = 1'b1;
    td = 32'd6;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (obs_rdy !== 1'b0) begin
        bad++; $display("FAIL bp_ready cyc=%0d got %b want 0", k, obs_rdy);
      end
      total++;
      if (obs_v !== 1'b1 || obs_d !== 32'd5) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b d=%0d want v=1 d=5", k, obs_v, obs_d);
      end
      @(posedge clk);
      #1;
    end
    tr = 1'b1;
    for (int i = 6; i < 16; i++) push(32'(i));
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (q_d.size() != 4) begin
      bad++; $display("FAIL bp_count got %0d want 4", q_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q_d[k] !== exp_d[k]) begin
          bad++; $display("FAIL bp_data idx=%0d got %0d want %0d", k, q_d[k], exp_d[k]);
        end
      end
    end
  endtask

  task automatic test_odd();
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd6; exp_d[1] = 32'd8; exp_d[2] = 32'd16; exp_d[3] = 32'd18;
    sel = 3;
    stim.delete();
    for (int i = 0; i < 25; i++) stim.push_back(32'(i));
    for (int f = 0; f < 2; f++) begin
      start_capture();
      send_stim();
      total++;
      if (q_d.size() != 4) begin
        bad++; $display("FAIL odd_count frame=%0d got %0d want 4", f, q_d.size());
      end else begin
        for (int k = 0; k < 4; k++) begin
          total++;
          if (q_d[k] !== exp_d[k]) begin
            bad++; $display("FAIL odd_data frame=%0d idx=%0d got %0d want %0d", f, k, q_d[k], exp_d[k]);
          end
          total++;
          if (q_l[k] !== (k == 3)) begin
            bad++; $display("FAIL odd_last frame=%0d idx=%0d got %b want %b", f, k, q_l[k], (k == 3));
          end
        end
      end
    end
  endtask

  task automatic check_fresh_frame(input string tag);
    logic [31:0] exp_d [4];
    exp_d[0] = 32'd5; exp_d[1] = 32'd7; exp_d[2] = 32'd13; exp_d[3] = 32'd15;
    start_capture();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(32'(i));
    send_stim();
    total++;
    if (q_d.size() != 4) begin
      bad++; $display("FAIL %s_count got %0d want 4", tag, q_d.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (q_d[k] !== exp_d[k] || q_l[k] !== (k == 3)) begin
          bad++; $display("FAIL %s_data idx=%0d got %0d last=%b want %0d last=%b",
                          tag, k, q_d[k], q_l[k], exp_d[k], (k == 3));
        end
      end
    end
  endtask

  task automatic test_frm_clr();
    sel = 0;
    mon_en = 1'b0;
    for (int i = 0; i < 6; i++) push(32'(i));
    tclr = 1'b1;
    tv = 1'b1;
    td = 32'd99;
    @(negedge clk);
    total++;
    if (obs_rdy !== 1'b0) begin
      bad++; $display("FAIL clr_ready got %b want 0", obs_rdy);
    end
    @(posedge clk);
    #1;
    tclr = 1'b0;
    tv = 1'b0;
    @(negedge clk);
    total++;
    if (obs_v !== 1'b0 || obs_l !== 1'b0) begin
      bad++; $display("FAIL clr_drop got v=%b l=%b want 0 0", obs_v, obs_l);
    end
    @(posedge clk);
    #1;
    check_fresh_frame("clr");
  endtask

  task automatic test_rst_mid();
    sel = 0;
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) push(32'(i));
    tr = 1'b0;
    push(32'd5);
    @(negedge clk);
    total++;
    if (obs_v !== 1'b1 || obs_d !== 32'd5) begin
      bad++; $display("FAIL rst_pre got v=%b d=%0d want v=1 d=5", obs_v, obs_d);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs_v !== 1'b0 || obs_l !== 1'b0 || obs_d !== 32'h0) begin
      bad++; $display("FAIL rst_async got v=%b l=%b d=%h want 0 0 0", obs_v, obs_l, obs_d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tr = 1'b1;
    @(posedge clk);
    #1;
    check_fresh_frame("rst");
  endtask

  initial begin
    rst_n  = 1'b0;
    sel    = 0;
    tv     = 1'b0;
    td     = '0;
    tr     = 1'b1;
    tclr   = 1'b0;
    mon_en = 1'b0;
    test_reset();
    test_max();
    test_avg();
    test_relu();
    test_backpressure();
    test_odd();
    test_frm_clr();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
